// File: rtl/polynomial_output_accumulator_if.sv
// Signal bundle between the tiled multiplier, the product accumulator and the
// downstream NTT/reduction stage; master drives tiles and readout ready.
interface polynomial_output_accumulator_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int POLY_A_WIDTH      = 27,
  parameter int POLY_B_WIDTH      = 27,
  parameter int POLY_A_TILE_WIDTH = 3,
  parameter int POLY_B_TILE_WIDTH = 9
);
  localparam int TILE_OUT = POLY_A_TILE_WIDTH + POLY_B_TILE_WIDTH - 1;
  localparam int C_LEN    = POLY_A_WIDTH + POLY_B_WIDTH - 1;
  localparam int IDX_W    = $clog2(C_LEN);

  logic                                 start;
  logic                                 wrap_mode;
  logic                                 tile_ready;
  logic [TILE_OUT-1:0][DATA_WIDTH-1:0]  adder_tree_outputs;
  logic                                 busy;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [IDX_W-1:0]                     out_index;
  logic                                 out_last;
  logic                                 done;
  logic                                 tile_overrun;

  modport master (
    output start, wrap_mode, tile_ready, adder_tree_outputs, out_ready,
    input  busy, out_valid, out_data, out_index, out_last, done, tile_overrun
  );

  modport slave (
    input  start, wrap_mode, tile_ready, adder_tree_outputs, out_ready,
    output busy, out_valid, out_data, out_index, out_last, done, tile_overrun
  );
endinterface

// File: rtl/polynomial_output_accumulator.sv
// Accumulates tile partial products into the full product store (1 cycle per tile edge),
// then streams it linear or folded mod x^N+1; readout holds data/index while out_ready is low.
module polynomial_output_accumulator #(
  parameter int DATA_WIDTH        = 16,
  parameter int POLY_A_WIDTH      = 27,
  parameter int POLY_B_WIDTH      = 27,
  parameter int POLY_A_TILE_WIDTH = 3,
  parameter int POLY_B_TILE_WIDTH = 9
) (
  input  logic clk,
  input  logic rst,
  polynomial_output_accumulator_if.slave bus
);
  localparam int TILE_OUT    = POLY_A_TILE_WIDTH + POLY_B_TILE_WIDTH - 1;
  localparam int C_LEN       = POLY_A_WIDTH + POLY_B_WIDTH - 1;
  localparam int N           = POLY_A_WIDTH;
  localparam int NUM_A_TILES = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
  localparam int NUM_B_TILES = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
  localparam int NUM_TILES   = NUM_A_TILES * NUM_B_TILES;
  localparam int IDX_W       = $clog2(C_LEN);
  localparam int CNT_W       = $clog2(NUM_TILES + 1);
  localparam int IA_W        = (NUM_A_TILES > 1) ? $clog2(NUM_A_TILES + 1) : 1;
  localparam int IB_W        = (NUM_B_TILES > 1) ? $clog2(NUM_B_TILES) : 1;

  localparam logic [IDX_W-1:0] LAST_LIN = IDX_W'(C_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_NEG = IDX_W'(N - 1);

  if (POLY_A_WIDTH % POLY_A_TILE_WIDTH != 0) begin : g_bad_a_tile
    $error("POLY_A_TILE_WIDTH must divide POLY_A_WIDTH");
  end
  if (POLY_B_WIDTH % POLY_B_TILE_WIDTH != 0) begin : g_bad_b_tile
    $error("POLY_B_TILE_WIDTH must divide POLY_B_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                             state_q;
  state_t                             state_d;
  logic [C_LEN-1:0][DATA_WIDTH-1:0]   coef_q;
  logic [CNT_W-1:0]                   tile_cnt_q;
  logic [IA_W-1:0]                    ia_q;
  logic [IB_W-1:0]                    ib_q;
  logic [IDX_W-1:0]                   rd_idx_q;
  logic                               tile_ready_q;
  logic                               wrap_q;
  logic                               done_q;
  logic                               overrun_q;

  logic                               tile_edge;
  logic                               start_accept;
  logic                               accept_tile;
  logic                               last_tile;
  logic                               handshake;
  logic                               rd_last;
  logic [IDX_W-1:0]                   base;
  logic [DATA_WIDTH-1:0]              rd_lo;
  logic [DATA_WIDTH-1:0]              rd_hi;
  logic                               rd_has_hi;
  logic [DATA_WIDTH-1:0]              rd_word;

  assign tile_edge    = bus.tile_ready & ~tile_ready_q;
  assign start_accept = (state_q == IDLE) & bus.start;
  assign accept_tile  = (state_q == ACCUM) & tile_edge;
  assign last_tile    = (tile_cnt_q == CNT_W'(NUM_TILES - 1));
  assign handshake    = (state_q == DRAIN) & bus.out_ready;
  assign rd_last      = (rd_idx_q == (wrap_q ? LAST_NEG : LAST_LIN));

  // B-tile index runs fastest, so the tile lands at ia*TA + ib*TB.
  assign base = IDX_W'(int'(ia_q) * POLY_A_TILE_WIDTH + int'(ib_q) * POLY_B_TILE_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (accept_tile && last_tile) state_d = DRAIN;
      DRAIN:   if (handshake && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= '0;
    end else if (start_accept) begin
      coef_q <= '0;
    end else if (accept_tile) begin
      for (int k = 0; k < TILE_OUT; k++) begin
        coef_q[base + IDX_W'(k)] <= coef_q[base + IDX_W'(k)] + bus.adder_tree_outputs[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_ready_q <= 1'b0;
      tile_cnt_q   <= '0;
      ia_q         <= '0;
      ib_q         <= '0;
      wrap_q       <= 1'b0;
      rd_idx_q     <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tile_ready_q <= bus.tile_ready;
      done_q       <= handshake & rd_last;
      overrun_q    <= tile_edge & (state_q != ACCUM);

      if (start_accept) begin
        tile_cnt_q <= '0;
        ia_q       <= '0;
        ib_q       <= '0;
        wrap_q     <= bus.wrap_mode;
      end else if (accept_tile) begin
        tile_cnt_q <= tile_cnt_q + 1'b1;
        if (ib_q == IB_W'(NUM_B_TILES - 1)) begin
          ib_q <= '0;
          ia_q <= ia_q + 1'b1;
        end else begin
          ib_q <= ib_q + 1'b1;
        end
      end

      if (accept_tile && last_tile) begin
        rd_idx_q <= '0;
      end else if (handshake) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
    end
  end

  // Negacyclic fold: the upper half re-enters at index j-N with negated sign.
  always_comb begin
    rd_lo     = '0;
    rd_hi     = '0;
    rd_has_hi = 1'b0;
    for (int j = 0; j < C_LEN; j++) begin
      if (rd_idx_q == IDX_W'(j)) rd_lo = coef_q[j];
    end
    for (int j = N; j < C_LEN; j++) begin
      if (rd_idx_q == IDX_W'(j - N)) begin
        rd_hi     = coef_q[j];
        rd_has_hi = 1'b1;
      end
    end
  end

  assign rd_word = (wrap_q && rd_has_hi) ? (rd_lo - rd_hi) : rd_lo;

  assign bus.busy         = (state_q != IDLE);
  assign bus.out_valid    = (state_q == DRAIN);
  assign bus.out_data     = (state_q == DRAIN) ? rd_word : '0;
  assign bus.out_index    = (state_q == DRAIN) ? rd_idx_q : '0;
  assign bus.out_last     = (state_q == DRAIN) & rd_last;
  assign bus.done         = done_q;
  assign bus.tile_overrun = overrun_q;
endmodule

// File: tb/tb_polynomial_output_accumulator.sv
// Directed bench for polynomial_output_accumulator with default parameters
// (53-word linear product, 27-word negacyclic fold).
module tb_polynomial_output_accumulator;
  localparam int DW = 16;
  localparam int PA = 27;
  localparam int PB = 27;
  localparam int TA = 3;
  localparam int TB = 9;
  localparam int TILE_OUT = TA + TB - 1;

  logic clk = 1'b0;
  logic rst;

  polynomial_output_accumulator_if #(
    .DATA_WIDTH(DW), .POLY_A_WIDTH(PA), .POLY_B_WIDTH(PB),
    .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB)
  ) bus ();

  polynomial_output_accumulator #(
    .DATA_WIDTH(DW), .POLY_A_WIDTH(PA), .POLY_B_WIDTH(PB),
    .POLY_A_TILE_WIDTH(TA), .POLY_B_TILE_WIDTH(TB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] got_data [64];
  logic [5:0]  got_idx  [64];
  logic        got_last [64];
  int          nwords;
  int          hold_viol;
  bit          done_ok;

  // kind 0: full triangle, 1: negacyclic fold, 2: all-0xFFFF tiles, 3: negated triangle
  function automatic logic [15:0] expected(input int kind, input int j);
    int v;
    int n;
    int b;
    v = j + 1;
    if (v > 27) v = 27;
    if (53 - j < v) v = 53 - j;
    case (kind)
      0: return 16'(v);
      1: return (j < 26) ? 16'(2 * j - 25) : 16'd27;
      2: begin
        n = 0;
        for (int ia = 0; ia < 9; ia++) begin
          for (int ib = 0; ib < 3; ib++) begin
            b = 3 * ia + 9 * ib;
            if (j >= b && j <= b + 10) n++;
          end
        end
        return 16'h0000 - 16'(n);
      end
      default: return 16'h0000 - 16'(v);
    endcase
  endfunction

  task automatic set_tile(input int mode);
    logic [15:0] t;
    for (int k = 0; k < TILE_OUT; k++) begin
      t = (k < 2) ? 16'(k + 1) : (k > 8) ? 16'(11 - k) : 16'd3;
      case (mode)
        0:       bus.adder_tree_outputs[k] = t;
        1:       bus.adder_tree_outputs[k] = 16'hFFFF;
        default: bus.adder_tree_outputs[k] = 16'h0000 - t;
      endcase
    end
  endtask

  task automatic start_run(input bit w);
    bus.out_ready = 1'b0;
    bus.wrap_mode = w;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.wrap_mode = 1'b0;
  endtask

  task automatic send_tiles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tile_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.tile_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic collect(input bit stall, output bit timeout);
    bit pend;
    bit fin;
    logic [15:0] pd;
    logic [5:0]  pi;
    nwords = 0; hold_viol = 0; done_ok = 0;
    pend = 0; fin = 0; timeout = 1; pd = '0; pi = '0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      bus.out_ready = stall ? cyc[0] : 1'b1;
      if (pend && (bus.out_data !== pd || bus.out_index !== pi)) hold_viol++;
      pend = 0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          if (nwords < 64) begin
            got_data[nwords] = bus.out_data;
            got_idx[nwords]  = bus.out_index;
            got_last[nwords] = bus.out_last;
          end
          nwords++;
          if (bus.out_last === 1'b1) begin
            @(negedge clk);
            done_ok = (bus.done === 1'b1) && (bus.out_valid === 1'b0);
            fin = 1;
            timeout = 0;
          end
        end else begin
          pend = 1;
          pd = bus.out_data;
          pi = bus.out_index;
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.wrap_mode = 0; bus.tile_ready = 0; bus.out_ready = 0;
    bus.adder_tree_outputs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.tile_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b vld=%b done=%b ovr=%b required all 0",
               bus.busy, bus.out_valid, bus.done, bus.tile_overrun);
    end
    checks++;
    if (bus.out_data !== 16'h0 || bus.out_index !== 6'h0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got data=%h idx=%0d last=%b required 0", bus.out_data, bus.out_index, bus.out_last);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_linear();
    bit to;
    set_tile(0);
    start_run(0);
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lin_accum_busy got busy=%b vld=%b required 1/0", bus.busy, bus.out_valid);
    end
    send_tiles(27);
    collect(0, to);
    checks++;
    if (to || nwords !== 53) begin
      errors++;
      $display("FAIL lin_count got words=%0d timeout=%b required 53/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_idx[j] !== 6'(j) || got_data[j] !== expected(0, j) || got_last[j] !== (j == 52)) begin
        errors++;
        $display("FAIL lin_word[%0d] got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                 j, got_idx[j], got_data[j], got_last[j], j, expected(0, j), (j == 52));
      end
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL lin_done got done/valid after last not 1/0 required 1/0");
    end
  endtask

  task automatic test_negacyclic();
    bit to;
    set_tile(0);
    start_run(1);
    send_tiles(27);
    collect(0, to);
    checks++;
    if (to || nwords !== 27) begin
      errors++;
      $display("FAIL neg_count got words=%0d timeout=%b required 27/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_idx[j] !== 6'(j) || got_data[j] !== expected(1, j) || got_last[j] !== (j == 26)) begin
        errors++;
        $display("FAIL neg_word[%0d] got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                 j, got_idx[j], got_data[j], got_last[j], j, expected(1, j), (j == 26));
      end
    end
    checks++;
    if (!done_ok) begin
      errors++;
      $display("FAIL neg_done got done/valid after last not 1/0 required 1/0");
    end
  endtask

  task automatic test_backpressure();
    bit to;
    set_tile(0);
    start_run(0);
    send_tiles(27);
    collect(1, to);
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d changes while stalled required 0", hold_viol);
    end
    checks++;
    if (to || nwords !== 53) begin
      errors++;
      $display("FAIL bp_count got words=%0d timeout=%b required 53/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_idx[j] !== 6'(j) || got_data[j] !== expected(0, j)) begin
        errors++;
        $display("FAIL bp_word[%0d] got idx=%0d data=%h required idx=%0d data=%h",
                 j, got_idx[j], got_data[j], j, expected(0, j));
      end
    end
  endtask

  task automatic test_overflow();
    bit to;
    // Every tile element 0xFFFF: each index collects -1 once per tile covering it.
    set_tile(1);
    start_run(0);
    send_tiles(27);
    collect(0, to);
    checks++;
    if (to || nwords !== 53) begin
      errors++;
      $display("FAIL ovf_ones_count got words=%0d timeout=%b required 53/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_data[j] !== expected(2, j)) begin
        errors++;
        $display("FAIL ovf_ones_word[%0d] got %h required %h", j, got_data[j], expected(2, j));
      end
    end
    // Negated triangle tiles: c[0]=0xFFFF, c[26]=27*0xFFFF mod 2^16=0xFFE5.
    set_tile(2);
    start_run(0);
    send_tiles(27);
    collect(0, to);
    checks++;
    if (to || nwords !== 53) begin
      errors++;
      $display("FAIL ovf_neg_count got words=%0d timeout=%b required 53/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_data[j] !== expected(3, j)) begin
        errors++;
        $display("FAIL ovf_neg_word[%0d] got %h required %h", j, got_data[j], expected(3, j));
      end
    end
  endtask

  task automatic test_tile_edges();
    bit to;
    int cnt;
    bit seen;
    set_tile(0);
    // Edge while idle: one overrun pulse, nothing starts.
    @(posedge clk); #1;
    bus.tile_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.tile_overrun === 1'b1) cnt++;
      if (i == 2) bus.tile_ready = 1'b0;
    end
    checks++;
    if (cnt !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_overrun got pulses=%0d busy=%b required 1/0", cnt, bus.busy);
    end
    start_run(0);
    bus.tile_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.tile_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_tiles(25);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL long_tile_one got vld=%b busy=%b after 26 tiles required 0/1", bus.out_valid, bus.busy);
    end
    send_tiles(1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drain_entry got no out_valid within 20 cycles required 1");
    end
    // Edge while draining: one overrun pulse, store untouched.
    bus.tile_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.tile_overrun === 1'b1) cnt++;
      if (i == 2) bus.tile_ready = 1'b0;
    end
    checks++;
    if (cnt !== 1 || bus.out_index !== 6'd0) begin
      errors++;
      $display("FAIL drain_overrun got pulses=%0d idx=%0d required 1/0", cnt, bus.out_index);
    end
    collect(0, to);
    checks++;
    if (to || nwords !== 53) begin
      errors++;
      $display("FAIL edge_count got words=%0d timeout=%b required 53/0", nwords, to);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_data[j] !== expected(0, j)) begin
        errors++;
        $display("FAIL edge_word[%0d] got %h required %h", j, got_data[j], expected(0, j));
      end
    end
  endtask

  task automatic test_reset_abort();
    bit to;
    set_tile(0);
    start_run(0);
    send_tiles(10);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got busy=%b vld=%b required 0/0", bus.busy, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(0);
    send_tiles(27);
    collect(0, to);
    checks++;
    if (to || nwords !== 53 || !done_ok) begin
      errors++;
      $display("FAIL abort_rerun got words=%0d timeout=%b done_ok=%b required 53/0/1", nwords, to, done_ok);
    end
    for (int j = 0; j < nwords && j < 64; j++) begin
      checks++;
      if (got_idx[j] !== 6'(j) || got_data[j] !== expected(0, j)) begin
        errors++;
        $display("FAIL abort_word[%0d] got idx=%0d data=%h required idx=%0d data=%h",
                 j, got_idx[j], got_data[j], j, expected(0, j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_negacyclic();
    test_backpressure();
    test_overflow();
    test_tile_edges();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
